// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between the instruction-fetch
// port and the load/store port, with a saturating contention counter for debug.
module rv_mem_arbiter #(
    parameter int unsigned width    = 32,
    parameter int unsigned addrsize = 8,
    parameter int unsigned cntbits  = 16
) (
    input  logic                clk,
    input  logic                nrst,

    input  logic                if_req,
    input  logic [addrsize-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [width-1:0]    if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [addrsize-1:0] d_addr,
    input  logic [width-1:0]    d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [width-1:0]    d_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [addrsize-1:0] mem_addr,
    output logic [width-1:0]    mem_wdata,
    input  logic [width-1:0]    mem_rdata,

    output logic [cntbits-1:0]  conflicts
);

    logic               last_q;     // winner of the last conflict: 1 = data, 0 = fetch
    logic               rsp_if_q;
    logic               rsp_d_q;
    logic               rsp_wr_q;
    logic [cntbits-1:0] conflicts_q;
    logic               both_req;
    logic               if_win;

    assign both_req = if_req & d_req;
    // Fetch wins when alone, or in a conflict that data won last time.
    assign if_win   = if_req & (~d_req | last_q);

    always_comb begin
        if_gnt    = nrst & if_win;
        d_gnt     = nrst & d_req & ~if_win;
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            last_q      <= 1'b1;
            rsp_if_q    <= 1'b0;
            rsp_d_q     <= 1'b0;
            rsp_wr_q    <= 1'b0;
            conflicts_q <= '0;
        end else begin
            rsp_if_q <= if_gnt;
            rsp_d_q  <= d_gnt;
            rsp_wr_q <= d_gnt & d_we;
            if (both_req) begin
                last_q <= d_gnt;
                if (conflicts_q != {cntbits{1'b1}}) begin
                    conflicts_q <= conflicts_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        if_rvalid = nrst & rsp_if_q;
        d_rvalid  = nrst & rsp_d_q;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !rsp_wr_q) ? mem_rdata : '0;
    end

    assign conflicts = conflicts_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: a transaction-level model checks every cycle,
// and literal expectations pin the key scenarios.
module tb_rv_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [7:0]  mem_addr;
    logic [15:0] conflicts;

    logic        if_gnt4, if_rvalid4, d_gnt4, d_rvalid4, mem_en4, mem_we4;
    logic [31:0] if_rdata4, d_rdata4, mem_wdata4;
    logic [7:0]  mem_addr4;
    logic [3:0]  conflicts4;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem    [256];
    logic [31:0] mmem   [256];

    always #5 clk = ~clk;

    rv_mem_arbiter #(.width(32), .addrsize(8), .cntbits(16)) dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflicts(conflicts)
    );

    // Narrow-counter instance fed the same stimulus; exercises saturation.
    rv_mem_arbiter #(.width(32), .addrsize(8), .cntbits(4)) dut4 (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt4),
        .if_rvalid(if_rvalid4), .if_rdata(if_rdata4),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata),
        .conflicts(conflicts4)
    );

    // Synchronous memory behind the main instance.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Model state: who won the last conflict, pending response, contention count.
    bit          m_last_d = 1'b1;
    bit          p_if = 1'b0;
    bit          p_d = 1'b0;
    logic [31:0] p_data = '0;
    int          m_cnt = 0;

    initial begin : compare
        bit          w_if, w_d, e_ifv, e_dv;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata, e_ifd, e_dd;
        forever begin
            @(negedge clk);
            w_if    = nrst && if_req && (!d_req || m_last_d);
            w_d     = nrst && d_req && !w_if;
            e_addr  = w_if ? if_addr : (w_d ? d_addr : 8'd0);
            e_wdata = w_d ? d_wdata : 32'd0;
            e_ifv   = nrst && p_if;
            e_dv    = nrst && p_d;
            e_ifd   = e_ifv ? p_data : 32'd0;
            e_dd    = e_dv ? p_data : 32'd0;

            chk("if_gnt",    32'(if_gnt),    32'(w_if));
            chk("d_gnt",     32'(d_gnt),     32'(w_d));
            chk("mem_en",    32'(mem_en),    32'(w_if || w_d));
            chk("mem_we",    32'(mem_we),    32'(w_d && d_we));
            chk("mem_addr",  32'(mem_addr),  32'(e_addr));
            chk("mem_wdata", mem_wdata,      e_wdata);
            chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
            chk("if_rdata",  if_rdata,       e_ifd);
            chk("d_rvalid",  32'(d_rvalid),  32'(e_dv));
            chk("d_rdata",   d_rdata,        e_dd);
            chk("conflicts", 32'(conflicts), 32'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("gnt4",      {mem_wdata4[31:4], 1'b0, mem_we4, d_gnt4, if_gnt4},
                             {e_wdata[31:4], 1'b0, w_d && d_we, w_d, w_if});
            chk("mem4",      {23'd0, mem_en4, mem_addr4}, {23'd0, w_if || w_d, e_addr});
            chk("rsp4",      {28'd0, mem_wdata4[3:0]} ^ {30'd0, if_rvalid4, d_rvalid4},
                             {28'd0, e_wdata[3:0]} ^ {30'd0, e_ifv, e_dv});
            chk("rdata4",    if_rdata4 ^ d_rdata4, e_ifd ^ e_dd);
            chk("conflicts4", 32'(conflicts4), 32'((m_cnt > 15) ? 15 : m_cnt));

            if (!nrst) begin
                m_last_d = 1'b1;
                p_if     = 1'b0;
                p_d      = 1'b0;
                p_data   = '0;
                m_cnt    = 0;
            end else begin
                p_if   = w_if;
                p_d    = w_d;
                p_data = w_if ? mmem[if_addr] : ((w_d && !d_we) ? mmem[d_addr] : 32'd0);
                if (w_d && d_we) mmem[d_addr] = d_wdata;
                if (if_req && d_req) begin
                    m_last_d = w_d;
                    m_cnt++;
                end
            end
        end
    end

    // Apply one cycle of inputs, returning just after the compare point.
    task automatic cyc(input logic rn, input logic fr, input logic [7:0] fa, input logic dr,
                       input logic dw, input logic [7:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        nrst = rn; if_req = fr; if_addr = fa;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            mmem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
        end
        mem[5]  = 32'hDEAD_BEEF;
        mmem[5] = 32'hDEAD_BEEF;

        // Reset held with both ports requesting.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 8'd7, 32'd0);
        chk("rst_no_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_cnt",    32'(conflicts), 32'd0);
        cyc(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 8'd7, 32'd0);
        chk("first_conflict_fetch", {30'd0, if_gnt, d_gnt}, 32'd2);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);

        // Single fetch from a preloaded word.
        cyc(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("fetch_gnt", 32'(if_gnt), 32'd1);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("fetch_no_drv", 32'(d_rvalid), 32'd0);

        // Store then load of the same word.
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd9, 32'h1234_5678);
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd9, 32'd0);
        chk("store_ack", {d_rdata[30:0], d_rvalid}, 32'd1);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("load_after_store", d_rdata, 32'h1234_5678);

        // Continuous contention from a fresh reset: F,D,F,D,F,D.
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 8'd2, 32'd0);
            chk("alternate", {30'd0, if_gnt, d_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
        end
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("cnt_six", 32'(conflicts), 32'd6);

        // Reset right after a load grant drops its response.
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 32'd0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("rst_drops_rsp", 32'(d_rvalid), 32'd0);
        cyc(1'b1, 1'b1, 8'd6, 1'b1, 1'b0, 8'd8, 32'd0);
        chk("last_is_data", 32'(if_gnt), 32'd1);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("cnt_after_rst", 32'(conflicts), 32'd1);

        // Long contention with mixed loads/stores; narrow counter saturates.
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, 8'(k), 1'b1, 1'((k / 2) % 2), 8'(32 + k / 2),
                32'hC0DE_0000 + 32'(k / 2));
        end
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("cnt4_sat", 32'(conflicts4), 32'd15);
        chk("cnt_21",   32'(conflicts), 32'd21);

        // Data-port store, then fetch sees it.
        cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'd40, 32'hCAFE_F00D);
        cyc(1'b1, 1'b1, 8'd40, 1'b0, 1'b0, 8'd0, 32'd0);
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("fetch_sees_store", if_rdata, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Two-port request/grant arbiter sharing the single synchronous memory of the RV32I core between the instruction-fetch port and the load/store data port. Each cycle it grants at most one request, drives the memory, and returns the read data or write acknowledge one cycle later on the winning port. It sits between the core's fetch and load/store logic and the memory array. It also keeps a saturating count of contention cycles for debug.

## Interface
- `width`, 32, data bus width.
- `addrsize`, 8, word-address width.
- `cntbits`, 16, width of the contention counter.

- `clk`  in  1  clock; all state changes on its rising edge.
- `nrst`  in  1  synchronous active-low reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  addrsize  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  width  fetch data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  addrsize  data word address.
- `d_wdata`  in  width  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid or store acknowledge.
- `d_rdata`  out  width  load data; 0 on a store acknowledge.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  addrsize  memory address.
- `mem_wdata`  out  width  memory write data.
- `mem_rdata`  in  width  memory read data, valid the cycle after a read.
- `conflicts`  out  cntbits  number of cycles in which both ports requested.

## Operation
- **Request rules.** A requester holds `req`, `addr`, `we` and `wdata` stable from assertion until it sees `gnt`. A request completes in the cycle `gnt` is high. The requester may drop `req` or present a new request in the next cycle.
- **Grant selection.** Grant is combinational from this cycle's requests and registered state. Exactly one of `if_gnt`/`d_gnt` is high when at least one `req` is high. Neither is high when neither `req` is high.
- **Arbitration.**
  - Only one port requesting: that port wins.
  - Both ports requesting: round robin on `last`, a 1-bit register holding the last winner of a conflict cycle.
  - The port that did not win the previous conflict wins this one, and `last` updates.
  - Reset value `last` = data, so fetch wins the first conflict.
  - `last` changes only in conflict cycles.
- **Memory drive.**
  - `mem_en` = any grant.
  - `mem_addr` / `mem_we` / `mem_wdata` come from the winning port.
  - Fetch grants always have `mem_we` = 0.
  - When idle: `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0.
- **Response state.** Registered `rsp_if`, `rsp_d` and `rsp_wr` capture the grant type.
  - `if_rvalid` = `rsp_if`, with `if_rdata` = `mem_rdata`.
  - `d_rvalid` = `rsp_d`, with `d_rdata` = (`rsp_wr` ? 0 : `mem_rdata`).
  - Both rdata outputs are 0 when their rvalid is low.
- **Contention counter.** `conflicts` increments by 1 in every cycle where `if_req` & `d_req`, and saturates at all-ones (no wrap).
- **Reset.**
  - While `nrst` is low, all grants, `mem_en`, `mem_we` and both rvalids are forced to 0 combinationally.
  - On the clock edge: `rsp_*` = 0, `last` = data, `conflicts` = 0.
  - Reset asserted the cycle after a grant suppresses that grant's response. The requester must reissue.

## Timing
- **Latency.** Grant in cycle N; rvalid and data in cycle N+1.
- **Throughput.** One access per cycle, fully pipelined. A new grant can be issued in the same cycle as the previous grant's response.
- **Two-port bandwidth.** Under continuous contention, fetch and data alternate every cycle.
- **Store ordering.** Store data is written at the N edge. A load to the same address granted at N+1 returns the new data at N+2.
- **Combinational path.** There is a combinational path from `req`/`addr` to `gnt` and `mem_*`. Requesters must not make `req` depend on `gnt` combinationally.

## Test plan
- **Reset.** Hold `nrst` = 0 with both `req` = 1 → no grant, `mem_en` = 0, `conflicts` = 0. Release → first grant goes to fetch.
- **Single fetch.** Preload mem[5] = 0xDEADBEEF; `if_req`, `if_addr` = 5 for one cycle → `if_gnt` at N, `if_rvalid` at N+1 with 0xDEADBEEF, `d_rvalid` stays 0.
- **Store then load.** Store 0x12345678 to address 9, then load address 9 on the next cycle → `d_rvalid` with `d_rdata` = 0 at N+1; `d_rdata` = 0x12345678 at N+2.
- **Contention.** Both ports request continuously for 6 cycles → grants F,D,F,D,F,D, rvalids follow one cycle later, `conflicts` = 6.
- **Reset mid-operation.** Grant a load, assert `nrst` = 0 in the next cycle → no `d_rvalid`; after release, `conflicts` = 0 and `last` = data.
- **Saturation.** Set `cntbits` = 4 and hold contention for 20 cycles → `conflicts` stays at 15.
